// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared external ALU.
// One operation in flight; round-robin priority between requesters.
module alu_arbiter #(
    parameter int WIDTH     = 32,
    parameter bit FAIR_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req0_ctl,
    input  logic [3:0]       req1_ctl,
    output logic             resp0_valid,
    output logic             resp1_valid,
    input  logic             resp0_ready,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic [1:0]       resp_zero,
    output logic             resp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [1:0]       alu_zero
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state;
    logic   prio;
    logic   owner;
    logic   idle;
    logic   grant0;
    logic   grant1;
    logic   ctl_ok;
    logic   resp_take;

    // prio names the requester that wins when both are valid
    assign idle   = (state == IDLE);
    assign grant0 = idle & req0_valid & (~req1_valid | ~prio);
    assign grant1 = idle & req1_valid & (~req0_valid | prio);

    assign req0_ready = rst_n & grant0;
    assign req1_ready = rst_n & grant1;

    assign resp_take = owner ? resp1_ready : resp0_ready;

    always_comb begin
        ctl_ok = 1'b0;
        case (alu_ctl)
            4'b0000, 4'b0001, 4'b0010,
            4'b0110, 4'b0111, 4'b1100: ctl_ok = 1'b1;
            default:                   ctl_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            prio        <= FAIR_INIT;
            owner       <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_ctl     <= 4'b0000;
            resp_data   <= '0;
            resp_zero   <= 2'b00;
            resp_err    <= 1'b0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 | grant1) begin
                        alu_a   <= grant1 ? req1_a : req0_a;
                        alu_b   <= grant1 ? req1_b : req0_b;
                        alu_ctl <= grant1 ? req1_ctl : req0_ctl;
                        owner   <= grant1;
                        prio    <= grant0;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    resp_data   <= ctl_ok ? alu_out : '0;
                    resp_zero   <= ctl_ok ? alu_zero : 2'b00;
                    resp_err    <= ~ctl_ok;
                    resp0_valid <= ~owner;
                    resp1_valid <= owner;
                    state       <= RESP;
                end
                RESP: begin
                    if (resp_take) begin
                        resp0_valid <= 1'b0;
                        resp1_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width.
REQ-002 SHALL have parameter FAIR_INIT, default 0, meaning requester holding priority after reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req0_valid/req1_valid  input  1 each  requester N presents an operation.
REQ-006 SHALL have ports req0_ready/req1_ready  output  1 each  requester N operation accepted this cycle.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH each  operands.
REQ-008 SHALL have ports req0_ctl/req1_ctl  input  4 each  ALU control code.
REQ-009 SHALL have ports resp0_valid/resp1_valid  output  1 each  response for requester N available.
REQ-010 SHALL have ports resp0_ready/resp1_ready  input  1 each  requester N takes response.
REQ-011 SHALL have port resp_data  output  WIDTH  registered result, shared by both responders.
REQ-012 SHALL have port resp_zero  output  2  registered ALU zero flags.
REQ-013 SHALL have port resp_err  output  1  registered illegal-control flag.
REQ-014 SHALL have ports alu_a, alu_b  output  WIDTH each; alu_ctl  output  4  registered drive to shared ALU.
REQ-015 SHALL have ports alu_out  input  WIDTH; alu_zero  input  2  combinational ALU results.

Function
REQ-016 SHALL implement FSM states IDLE, EXEC, RESP; one transaction in flight at a time.
REQ-017 In IDLE, ready SHALL be asserted only to the granted requester, combinationally: only one valid -> that one; both valid -> requester holding priority.
REQ-018 On req handshake (valid & ready at edge), SHALL latch a, b, ctl into alu_a/alu_b/alu_ctl, record owner, toggle priority to the other requester, go to EXEC.
REQ-019 With no valid in IDLE, SHALL stay in IDLE and leave priority unchanged.
REQ-020 In EXEC (exactly one cycle), SHALL capture alu_out -> resp_data and alu_zero -> resp_zero, then go to RESP.
REQ-021 Legal ctl codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR; any other code SHALL set resp_err=1, resp_data=0, resp_zero=2'b00, still completing normally.
REQ-022 In RESP, SHALL assert respN_valid for owner only; hold resp_data/zero/err stable until respN_ready; on handshake go to IDLE.
REQ-023 Latency: handshake at edge N -> respN_valid high from cycle N+2; back-to-back throughput one op per 3 cycles minimum.
REQ-024 Both ready outputs SHALL be 0 outside IDLE; requests held across EXEC/RESP SHALL not be lost or duplicated.
REQ-025 Non-owner resp_ready SHALL be ignored.
REQ-026 Arithmetic is entirely the ALU's; block SHALL not modify alu_out beyond REQ-021.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, all ready/valid outputs 0, resp_data/alu_a/alu_b 0, alu_ctl 0000, resp_zero 00, resp_err 0, priority FAIR_INIT.
REQ-028 Reset asserted in EXEC or RESP SHALL abort the transaction; no response issued after release.
REQ-029 First acceptance SHALL be no earlier than first rising edge after rst_n deasserts.

Verification
REQ-030 req0 ADD a=0x55555555 b=0xAAAAAAAA -> resp0_valid 2 cycles later, resp_data=0xFFFFFFFF, resp_err=0.
REQ-031 After reset both valid (req0 SUB 0x12345678-0x12345678, req1 OR) -> req0 served first, resp_data=0, resp_zero indicates zero; req1 served next transaction.
REQ-032 req1 SLT a=0xAAAAAAAA b=0x55555555 -> resp1_valid, resp_data=0x00000001; resp0_valid stays 0.
REQ-033 req0 ctl=4'b0011 -> resp_err=1, resp_data=0; next legal op clears resp_err.
REQ-034 Hold resp0_ready=0 for 5 cycles in RESP -> resp0_valid and resp_data stable, both ready outputs 0; release -> IDLE next edge.
REQ-035 Drop rst_n during EXEC -> outputs zero asynchronously; after release no response, state IDLE.
